pri_decoder_2x4_seq: RTL and testbench

Registered decoder that is the inverse of the 4x2 priority encoder. It accepts a binary code through a valid/ready handshake and drives the matching one-hot line for HOLD clock cycles, then returns to all-zero. It sits downstream of the priority encoder and turns an encoded grant back into a timed one-hot select. A `done` pulse marks the end of each grant window.

---
 rtl/pri_codec_pkg.sv | 22 ++
 rtl/pri_decoder_2x4_seq_hold_cnt.sv | 33 +++
 rtl/pri_decoder_2x4_seq.sv | 96 +++++++++
 tb/tb_pri_decoder_2x4_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pri_codec_pkg.sv
// Shared constants and helpers for the priority encoder/decoder pair.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pri_codec_pkg;

  // Default code width and hold length.
  localparam int W_DEF    = 2;
  localparam int HOLD_DEF = 4;

  // Decoder window states, 1-bit encoded.
  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  // One-hot of a binary code. Result is 32 bits wide, so callers slice
  // down to their own N; codes wider than 5 bits are not supported.
  function automatic logic [31:0] onehot(input logic [4:0] code);
    return 32'd1 << code;
  endfunction

endpackage

// File: rtl/pri_decoder_2x4_seq_hold_cnt.sv
// Loadable down-counter with zero flag; times one grant window.
// Latency: load/decrement/clear take effect on the next clk edge.
// Backpressure: none; driven purely by the owning FSM.
module hold_cnt #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] cnt;

  // Count register: clear wins over load, load wins over decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pri_decoder_2x4_seq.sv
// Registered 2**W one-hot decoder holding each accepted code for HOLD cycles.
// Latency: y valid the cycle after the accepting edge; done pulses after y clears.
// Backpressure: in_ready low while a window is active; producer holds in_valid/in_code.
module pri_decoder_2x4_seq
  import pri_codec_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int HOLD = HOLD_DEF,
  parameter int CW   = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           in_valid,
  input  logic [W-1:0]   in_code,
  output logic           in_ready,
  output logic [2**W-1:0] y,
  output logic           busy,
  output logic           done
);

  localparam int N        = 2**W;
  // A zero hold still produces a one-cycle window.
  localparam int HOLD_EFF = (HOLD < 1) ? 1 : HOLD;
  localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD_EFF - 1);

  state_t       state, state_nxt;
  logic [N-1:0] y_nxt;
  logic         done_nxt;
  logic         cnt_clr, cnt_load, cnt_dec, cnt_zero;

  assign in_ready = (state == S_IDLE);
  assign busy     = (state == S_ACTIVE);

  hold_cnt #(.CW(CW)) u_hold_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Next state and outputs: flush overrides both accept and expiry.
  always_comb begin
    state_nxt = state;
    y_nxt     = y;
    done_nxt  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    if (flush) begin
      state_nxt = S_IDLE;
      y_nxt     = '0;
      cnt_clr   = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state_nxt = S_ACTIVE;
            y_nxt     = N'(onehot(5'(in_code)));
            cnt_load  = 1'b1;
          end
        end
        S_ACTIVE: begin
          if (cnt_zero) begin
            state_nxt = S_IDLE;
            y_nxt     = '0;
            done_nxt  = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          y_nxt     = '0;
        end
      endcase
    end
  end

  // State and registered outputs; reset clears the window without a done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      y     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      y     <= y_nxt;
      done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_pri_decoder_2x4_seq.sv
// Directed bench for pri_decoder_2x4_seq (HOLD=4 main instance, HOLD=0 corner instance).
// Latency: checks taken on the falling edge after each rising edge.
// Backpressure: producer holds in_valid/in_code until accepted.
module tb_pri_decoder_2x4_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic [1:0] in_code;

  logic       in_ready, busy, done;
  logic [3:0] y;
  logic       in_ready_h0, busy_h0, done_h0;
  logic [3:0] y_h0;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] sweep_exp [4];

  pri_decoder_2x4_seq #(.W(2), .HOLD(4), .CW(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_code  (in_code),
    .in_ready (in_ready),
    .y        (y),
    .busy     (busy),
    .done     (done)
  );

  pri_decoder_2x4_seq #(.W(2), .HOLD(0), .CW(3)) dut_h0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_code  (in_code),
    .in_ready (in_ready_h0),
    .y        (y_h0),
    .busy     (busy_h0),
    .done     (done_h0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // y must be zero or one-hot at every sample point.
  always @(negedge clk) begin
    chk("y_onehot0", 32'($onehot0(y)), 32'd1);
  end

  initial begin
    sweep_exp[0] = 4'b0001;
    sweep_exp[1] = 4'b0010;
    sweep_exp[2] = 4'b0100;
    sweep_exp[3] = 4'b1000;

    // 1. Reset with a pending code on the bus.
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_code = 2'b11;
    tick(); tick();
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("rel_y", 32'(y), 32'h0);
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // 2. Single accept of code 2.
    in_valid = 1'b1; in_code = 2'b10;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("single_y", 32'(y), 32'h4);
      chk("single_busy", 32'(busy), 32'd1);
      chk("single_done", 32'(done), 32'd0);
      if (i < 3) tick();
    end
    tick();
    chk("single_end_y", 32'(y), 32'h0);
    chk("single_end_done", 32'(done), 32'd1);
    chk("single_end_ready", 32'(in_ready), 32'd1);
    tick();
    chk("single_done_clr", 32'(done), 32'd0);

    // 3. Back-to-back sweep with in_valid held high.
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_code = 2'(c);
      for (int k = 0; k < 4; k++) begin
        tick();
        chk("sweep_y", 32'(y), 32'(sweep_exp[c]));
        chk("sweep_ready", 32'(in_ready), 32'd0);
      end
      tick();
      chk("sweep_gap_y", 32'(y), 32'h0);
      chk("sweep_gap_done", 32'(done), 32'd1);
    end
    in_valid = 1'b0;
    tick();

    // 4. Code changes while active are ignored.
    in_valid = 1'b1; in_code = 2'b01;
    tick();
    chk("busy_first_y", 32'(y), 32'h2);
    in_code = 2'b11;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("busy_hold_y", 32'(y), 32'h2);
      chk("busy_hold_ready", 32'(in_ready), 32'd0);
    end
    tick();
    chk("busy_done", 32'(done), 32'd1);
    chk("busy_gap_y", 32'(y), 32'h0);
    tick();
    chk("busy_second_y", 32'(y), 32'h8);
    in_valid = 1'b0;
    repeat (5) tick();
    chk("busy_idle", 32'(in_ready), 32'd1);

    // 5. Flush mid-window, then flush racing a valid in IDLE.
    in_valid = 1'b1; in_code = 2'b11;
    tick();
    chk("flush_pre_y", 32'(y), 32'h8);
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    chk("flush_y", 32'(y), 32'h0);
    chk("flush_done", 32'(done), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    flush = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("flush_no_done", 32'(done), 32'd0);
    end
    flush = 1'b1; in_valid = 1'b1; in_code = 2'b10;
    tick();
    chk("flush_vld_y", 32'(y), 32'h0);
    chk("flush_vld_busy", 32'(busy), 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("flush_vld_y2", 32'(y), 32'h0);

    // 6. Asynchronous reset mid-window.
    in_valid = 1'b1; in_code = 2'b00;
    tick();
    chk("arst_pre_y", 32'(y), 32'h1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_y", 32'(y), 32'h0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("arst_no_done", 32'(done), 32'd0);
    end

    // HOLD = 0 instance: one-cycle window.
    in_valid = 1'b1; in_code = 2'b10;
    tick();
    in_valid = 1'b0;
    chk("h0_y", 32'(y_h0), 32'h4);
    chk("h0_busy", 32'(busy_h0), 32'd1);
    tick();
    chk("h0_end_y", 32'(y_h0), 32'h0);
    chk("h0_done", 32'(done_h0), 32'd1);
    tick();
    chk("h0_done_clr", 32'(done_h0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
